sram_bus_bridge: RTL and testbench

Bridges the core's 32-bit byte-addressed load/store request channel onto the 64-bit-wide single-port memory macro interface. That interface has active-low chip enable, active-low write enable, active-low per-bit write mask and 1-cycle registered read data. The bridge sits directly upstream of the memory macro. It converts size/offset into a bit-write mask and replicated write data, extracts and zero-extends read lanes, flags illegal accesses, and returns one response per request over a valid/ready handshake.

---
 rtl/sram_bus_bridge_if.sv | 24 ++
 rtl/sram_bus_bridge.sv | 150 +++++++++++++++
 tb/tb_sram_bus_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_bridge_if.sv
// Core-side load/store request channel and its response channel.
// Signal suffixes are named from the bridge's point of view.
interface sram_bus_bridge_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/sram_bus_bridge.sv
// Bridges 32-bit byte-addressed load/store requests onto a 64-bit single-port
// memory macro with active-low enables, per-bit write mask and 1-cycle read data.
module sram_bus_bridge #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_bus_bridge_if.slave      bus,
  output logic                  mem_ceb_o,
  output logic                  mem_web_o,
  output logic [63:0]           mem_bweb_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [63:0]           mem_data_o,
  input  logic [63:0]           mem_data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  state_e        state_q;
  logic          req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic          ceb_q, web_q;
  logic [63:0]   bweb_q, data_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [2:0]    off_q;

  logic          accept;
  logic          err_d;
  logic [5:0]    lane_sh;
  logic [63:0]   lane_bits;
  logic [63:0]   bweb_d, wdata_d;
  logic [31:0]   rd_shift;
  logic [31:0]   rdata_d;

  // Request decode and read-lane extraction; all consumed at clock edges only.
  always_comb begin
    accept  = bus.req_valid_i & req_ready_q;
    lane_sh = {bus.req_addr_i[2:0], 3'b000};
    case (bus.req_size_i)
      2'b00:   begin lane_bits = 64'h0000_0000_0000_00FF; wdata_d = {8{bus.req_wdata_i[7:0]}};  end
      2'b01:   begin lane_bits = 64'h0000_0000_0000_FFFF; wdata_d = {4{bus.req_wdata_i[15:0]}}; end
      default: begin lane_bits = 64'h0000_0000_FFFF_FFFF; wdata_d = {2{bus.req_wdata_i}};       end
    endcase
    bweb_d = ~(lane_bits << lane_sh);
    err_d  = (bus.req_size_i == 2'b11)
           | ((bus.req_size_i == 2'b01) & bus.req_addr_i[0])
           | ((bus.req_size_i == 2'b10) & (bus.req_addr_i[1:0] != 2'b00))
           | ({3'b000, bus.req_addr_i[31:3]} >= 32'(DEPTH));

    rd_shift = 32'(mem_data_i >> {off_q, 3'b000});
    case (size_q)
      2'b00:   rdata_d = {24'h0, rd_shift[7:0]};
      2'b01:   rdata_d = {16'h0, rd_shift[15:0]};
      default: rdata_d = rd_shift;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      ceb_q        <= 1'b1;
      web_q        <= 1'b1;
      bweb_q       <= '1;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            we_q        <= bus.req_we_i;
            size_q      <= bus.req_size_i;
            off_q       <= bus.req_addr_i[2:0];
            if (err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q <= ISSUE;
              ceb_q   <= 1'b0;
              web_q   <= ~bus.req_we_i;
              addr_q  <= bus.req_addr_i[AW+2:3];
              if (bus.req_we_i) begin
                bweb_q <= bweb_d;
                data_q <= wdata_d;
              end
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          ceb_q  <= 1'b1;
          web_q  <= 1'b1;
          bweb_q <= '1;
          addr_q <= '0;
          data_q <= '0;
          if (we_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= rdata_d;
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = resp_rdata_q;
  assign bus.resp_err_o   = resp_err_q;
  assign mem_ceb_o        = ceb_q;
  assign mem_web_o        = web_q;
  assign mem_bweb_o       = bweb_q;
  assign mem_addr_o       = addr_q;
  assign mem_data_o       = data_q;

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Directed bench for sram_bus_bridge against a behavioural 64-bit memory macro.
module tb_sram_bus_bridge;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_ceb, mem_web;
  logic [63:0]   mem_bweb, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad   = 0;
  int ceb_low_cnt = 0;
  int ceb_before;

  sram_bus_bridge_if bus ();

  sram_bus_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .mem_ceb_o  (mem_ceb),
    .mem_web_o  (mem_web),
    .mem_bweb_o (mem_bweb),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_data_i (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: masked write, read data registered one cycle after the enable.
  logic [63:0] mem_array [0:DEPTH-1];
  always @(posedge clk) begin
    if (!mem_ceb) begin
      ceb_low_cnt <= ceb_low_cnt + 1;
      if (!mem_web)
        mem_array[mem_addr] <= (mem_array[mem_addr] & mem_bweb) | (mem_wdata & ~mem_bweb);
      else
        mem_rdata <= mem_array[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns one cycle after the accepting edge (C+1).
  task automatic start_req(input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    while (!bus.req_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!bus.req_ready_o) check("ready_timeout", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_size_i  = size;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic check_idle_mem(input string tag);
    check({tag, "_ceb"},  64'(mem_ceb),  64'd1);
    check({tag, "_web"},  64'(mem_web),  64'd1);
    check({tag, "_bweb"}, mem_bweb,      {64{1'b1}});
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_data"}, mem_wdata,     64'd0);
  endtask

  // Read request; returns at C+3 with the response checked and consumed.
  task automatic do_read(input string tag, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] exp);
    start_req(1'b0, size, addr, 32'h0);
    check({tag, "_iss_ceb"}, 64'(mem_ceb), 64'd0);
    check({tag, "_iss_web"}, 64'(mem_web), 64'd1);
    tick();
    check({tag, "_cap_valid"}, 64'(bus.resp_valid_o), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(bus.resp_valid_o), 64'd1);
    check({tag, "_rdata"}, 64'(bus.resp_rdata_o), 64'(exp));
    check({tag, "_err"},   64'(bus.resp_err_o),   64'd0);
    tick();
  endtask

  task automatic do_error(input string tag, input logic [1:0] size, input logic [31:0] addr);
    start_req(1'b0, size, addr, 32'hFFFF_FFFF);
    check({tag, "_valid"}, 64'(bus.resp_valid_o), 64'd1);
    check({tag, "_err"},   64'(bus.resp_err_o),   64'd1);
    check({tag, "_rdata"}, 64'(bus.resp_rdata_o), 64'd0);
    tick();
    check({tag, "_ready_after"}, 64'(bus.req_ready_o), 64'd1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_size_i   = 2'b00;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;
    bus.resp_ready_i = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_ready", 64'(bus.req_ready_o),  64'd0);
    check("rst_valid", 64'(bus.resp_valid_o), 64'd0);
    check("rst_rdata", 64'(bus.resp_rdata_o), 64'd0);
    check("rst_err",   64'(bus.resp_err_o),   64'd0);
    check_idle_mem("rst");
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_ready", 64'(bus.req_ready_o), 64'd1);

    // Word write 0xC
    start_req(1'b1, 2'b10, 32'h0000_000C, 32'hDEAD_BEEF);
    check("ww_ceb",  64'(mem_ceb),  64'd0);
    check("ww_web",  64'(mem_web),  64'd0);
    check("ww_addr", 64'(mem_addr), 64'd1);
    check("ww_bweb", mem_bweb,      64'h0000_0000_FFFF_FFFF);
    check("ww_data", mem_wdata,     64'hDEAD_BEEF_DEAD_BEEF);
    check("ww_c1_valid", 64'(bus.resp_valid_o), 64'd0);
    tick();
    check("ww_valid", 64'(bus.resp_valid_o), 64'd1);
    check("ww_err",   64'(bus.resp_err_o),   64'd0);
    check("ww_rdata", 64'(bus.resp_rdata_o), 64'd0);
    check_idle_mem("ww_c2");
    tick();
    check("ww_ready_after", 64'(bus.req_ready_o), 64'd1);

    // Byte write 0xD
    start_req(1'b1, 2'b00, 32'h0000_000D, 32'h0000_005A);
    check("bw_bweb", mem_bweb,  64'h FFFF_00FF_FFFF_FFFF);
    check("bw_data", mem_wdata, 64'h5A5A_5A5A_5A5A_5A5A);
    tick();
    check("bw_valid", 64'(bus.resp_valid_o), 64'd1);
    tick();

    // Reads of the merged word
    do_read("rw", 2'b10, 32'h0000_000C, 32'hDEAD_5AEF);
    do_read("rh", 2'b01, 32'h0000_000E, 32'h0000_DEAD);
    do_read("rb", 2'b00, 32'h0000_000D, 32'h0000_005A);

    // Half write at 0xA then half read back
    start_req(1'b1, 2'b01, 32'h0000_000A, 32'h1234_C3A5);
    check("hw_bweb", mem_bweb,  64'hFFFF_FFFF_0000_FFFF);
    check("hw_data", mem_wdata, 64'hC3A5_C3A5_C3A5_C3A5);
    tick();
    tick();
    do_read("rh2", 2'b01, 32'h0000_000A, 32'h0000_C3A5);

    // Last valid word: byte at offset 7
    start_req(1'b1, 2'b00, 32'h0000_7FFF, 32'h0000_00A5);
    check("last_addr", 64'(mem_addr), 64'hFFF);
    check("last_bweb", mem_bweb,      64'h00FF_FFFF_FFFF_FFFF);
    tick();
    check("last_err", 64'(bus.resp_err_o), 64'd0);
    tick();
    do_read("rlast", 2'b00, 32'h0000_7FFF, 32'h0000_00A5);

    // Response backpressure
    bus.resp_ready_i = 1'b0;
    start_req(1'b0, 2'b10, 32'h0000_000C, 32'h0);
    tick();
    tick();
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h0000_0008;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(bus.resp_valid_o), 64'd1);
      check("bp_rdata", 64'(bus.resp_rdata_o), 64'hDEAD_5AEF);
      check("bp_ready", 64'(bus.req_ready_o),  64'd0);
      check("bp_ceb",   64'(mem_ceb),          64'd1);
      tick();
    end
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    tick();
    check("bp_released_valid", 64'(bus.resp_valid_o), 64'd0);
    check("bp_released_ready", 64'(bus.req_ready_o),  64'd1);

    // Illegal accesses never touch memory
    ceb_before = ceb_low_cnt;
    do_error("err_word_misalign", 2'b10, 32'h0000_0002);
    do_error("err_size11",        2'b11, 32'h0000_0000);
    do_error("err_range",         2'b00, 32'h0000_8000);
    do_error("err_half_odd",      2'b01, 32'h0000_0001);
    check("err_no_ceb", 64'(ceb_low_cnt - ceb_before), 64'd0);

    // Reset during CAPTURE drops the read
    start_req(1'b0, 2'b10, 32'h0000_0008, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 64'(bus.resp_valid_o), 64'd0);
    check("mid_rst_ready", 64'(bus.req_ready_o),  64'd0);
    check_idle_mem("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_resp", 64'(bus.resp_valid_o), 64'd0);
    end
    do_read("post_rst_rd", 2'b10, 32'h0000_000C, 32'hDEAD_5AEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
